// File: rtl/kara_mul_pipe.sv
`default_nettype none
// ============================================================================
// Module   : kara_mul_pipe
// Brief    : One-level Karatsuba WIDTH x WIDTH unsigned multiplier, valid/ready
//            streaming with full-pipeline stall and a pass-through tag.
// Revision : 1.0 - initial parametrised pipelined release
// ============================================================================
module kara_mul_pipe #(
    parameter int WIDTH      = 256,
    parameter int MUL_STAGES = 1,
    parameter int TAG_W      = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_p,
    output logic [TAG_W-1:0]     out_tag
);

    localparam int c_H  = WIDTH / 2;
    localparam int c_PW = 2 * c_H;
    localparam int c_MW = 2 * c_H + 2;
    localparam int c_OW = 2 * WIDTH;

    if ((WIDTH % 2) != 0 || WIDTH < 8) begin : g_chk_width
        $error("kara_mul_pipe: WIDTH must be even and >= 8");
    end
    if (MUL_STAGES < 1) begin : g_chk_stages
        $error("kara_mul_pipe: MUL_STAGES must be >= 1");
    end

    logic w_stall;
    assign w_stall  = out_valid && !out_ready;
    assign in_ready = !w_stall;

    // S0: operand capture
    logic               r_s0_valid;
    logic [WIDTH-1:0]   r_s0_a;
    logic [WIDTH-1:0]   r_s0_b;
    logic [TAG_W-1:0]   r_s0_tag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s0_valid <= 1'b0;
            r_s0_a     <= '0;
            r_s0_b     <= '0;
            r_s0_tag   <= '0;
        end else if (!w_stall) begin
            r_s0_valid <= in_valid;
            if (in_valid) begin
                r_s0_a   <= in_a;
                r_s0_b   <= in_b;
                r_s0_tag <= in_tag;
            end
        end
    end

    logic [c_H-1:0] w_a0, w_a1, w_b0, w_b1;
    logic [c_H:0]   w_sa, w_sb;
    logic [c_PW-1:0] w_p0, w_p2;
    logic [c_MW-1:0] w_pm;

    // Half sums keep their carry so pm stays exact.
    assign w_a0 = r_s0_a[c_H-1:0];
    assign w_a1 = r_s0_a[WIDTH-1:c_H];
    assign w_b0 = r_s0_b[c_H-1:0];
    assign w_b1 = r_s0_b[WIDTH-1:c_H];
    assign w_sa = {1'b0, w_a0} + {1'b0, w_a1};
    assign w_sb = {1'b0, w_b0} + {1'b0, w_b1};
    assign w_p0 = c_PW'(w_a0) * c_PW'(w_b0);
    assign w_p2 = c_PW'(w_a1) * c_PW'(w_b1);
    assign w_pm = c_MW'(w_sa) * c_MW'(w_sb);

    // Sub-product retiming chain; valid and tag travel alongside.
    logic [c_PW-1:0]  r_p0   [MUL_STAGES];
    logic [c_PW-1:0]  r_p2   [MUL_STAGES];
    logic [c_MW-1:0]  r_pm   [MUL_STAGES];
    logic             r_mv   [MUL_STAGES];
    logic [TAG_W-1:0] r_mtag [MUL_STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MUL_STAGES; i++) begin
                r_p0[i]   <= '0;
                r_p2[i]   <= '0;
                r_pm[i]   <= '0;
                r_mv[i]   <= 1'b0;
                r_mtag[i] <= '0;
            end
        end else if (!w_stall) begin
            r_p0[0]   <= w_p0;
            r_p2[0]   <= w_p2;
            r_pm[0]   <= w_pm;
            r_mv[0]   <= r_s0_valid;
            r_mtag[0] <= r_s0_tag;
            for (int i = 1; i < MUL_STAGES; i++) begin
                r_p0[i]   <= r_p0[i-1];
                r_p2[i]   <= r_p2[i-1];
                r_pm[i]   <= r_pm[i-1];
                r_mv[i]   <= r_mv[i-1];
                r_mtag[i] <= r_mtag[i-1];
            end
        end
    end

    logic [c_MW-1:0] w_mid;
    logic [c_OW-1:0] w_prod;

    // mid = a0*b1 + a1*b0 is never negative; the product's carry out of
    // 2*WIDTH bits is provably zero, so the sum is formed at 2*WIDTH bits.
    assign w_mid  = r_pm[MUL_STAGES-1] - c_MW'(r_p0[MUL_STAGES-1])
                                       - c_MW'(r_p2[MUL_STAGES-1]);
    assign w_prod = c_OW'(r_p0[MUL_STAGES-1])
                  + (c_OW'(w_mid) << c_H)
                  + (c_OW'(r_p2[MUL_STAGES-1]) << WIDTH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_p     <= '0;
            out_tag   <= '0;
        end else if (!w_stall) begin
            out_valid <= r_mv[MUL_STAGES-1];
            if (r_mv[MUL_STAGES-1]) begin
                out_p   <= w_prod;
                out_tag <= r_mtag[MUL_STAGES-1];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_kara_mul_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_kara_mul_pipe
// Brief    : Scoreboard bench for kara_mul_pipe (256/1, 64/3 and 8/1 builds).
// Revision : 1.0 - initial release
// ============================================================================
module tb_kara_mul_pipe;

    localparam int c_L = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         in_valid, in_ready, out_valid;
    logic         out_ready = 1'b1;
    logic [255:0] in_a, in_b;
    logic [3:0]   in_tag, out_tag;
    logic [511:0] out_p;

    kara_mul_pipe #(.WIDTH(256), .MUL_STAGES(1), .TAG_W(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .out_valid(out_valid),
        .out_ready(out_ready), .out_p(out_p), .out_tag(out_tag)
    );

    logic         v64, r64, ov64;
    logic [63:0]  a64, b64;
    logic [3:0]   t64, ot64;
    logic [127:0] p64;

    kara_mul_pipe #(.WIDTH(64), .MUL_STAGES(3), .TAG_W(4)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(v64), .in_ready(r64),
        .in_a(a64), .in_b(b64), .in_tag(t64), .out_valid(ov64),
        .out_ready(1'b1), .out_p(p64), .out_tag(ot64)
    );

    logic        v8, r8, ov8;
    logic [7:0]  a8, b8;
    logic [3:0]  t8, ot8;
    logic [15:0] p8;

    kara_mul_pipe #(.WIDTH(8), .MUL_STAGES(1), .TAG_W(4)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(r8),
        .in_a(a8), .in_b(b8), .in_tag(t8), .out_valid(ov8),
        .out_ready(1'b1), .out_p(p8), .out_tag(ot8)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int n_out    = 0;
    int n_out8   = 0;
    int cyc      = 0;
    logic bp_en  = 1'b0;

    typedef struct { logic [511:0] p; logic [3:0] t; } exp_t;
    exp_t        q[$];
    logic [15:0] q8[$];
    logic [511:0] drv_exp;

    function automatic void check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    function automatic logic [255:0] rnd256();
        logic [255:0] r = '0;
        for (int i = 0; i < 8; i++) r = {r[223:0], 32'($urandom())};
        return r;
    endfunction

    always @(posedge clk) begin
        cyc++;
        #1;
        out_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Main scoreboard: expectations pushed on accept, popped on transfer.
    logic         prev_stall = 1'b0;
    logic [511:0] prev_p;
    logic [3:0]   prev_t;
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            check("in_ready", 512'(in_ready), 512'(!(out_valid && !out_ready)));
            if (prev_stall) begin
                check("hold_valid", 512'(out_valid), 512'(1));
                check("hold_p", out_p, prev_p);
                check("hold_tag", 512'(out_tag), 512'(prev_t));
            end
            prev_stall = out_valid && !out_ready;
            prev_p     = out_p;
            prev_t     = out_tag;
            if (out_valid && out_ready) begin
                n_out++;
                if (q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_out: got p=%0h tag=%0d, none expected", out_p, out_tag);
                end else begin
                    e = q.pop_front();
                    check("out_p", out_p, e.p);
                    check("out_tag", 512'(out_tag), 512'(e.t));
                end
            end
            if (in_valid && in_ready) q.push_back('{drv_exp, in_tag});
        end else begin
            prev_stall = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (ov8) begin
                n_out8++;
                if (q8.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_out8: got %0h, none expected", p8);
                end else begin
                    check("out_p8", 512'(p8), 512'(q8.pop_front()));
                end
            end
            if (v8 && r8) q8.push_back(16'(a8) * 16'(b8));
        end
    end

    task automatic send(input logic [255:0] a, input logic [255:0] b,
                        input logic [3:0] t, input logic [511:0] e);
        in_a = a; in_b = b; in_tag = t; drv_exp = e; in_valid = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 1000 && !in_ready; k++) @(negedge clk);
        if (!in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: got in_ready=0, expected 1");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Issues into an idle pipeline and counts edges, accept edge included.
    task automatic timed(input logic [255:0] a, input logic [255:0] b,
                         input logic [3:0] t, input logic [511:0] e);
        int cnt;
        in_a = a; in_b = b; in_tag = t; drv_exp = e; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        cnt = 1;
        while (!out_valid && cnt < 20) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        check("latency", 512'(cnt), 512'(c_L));
        check("direct_p", out_p, e);
        check("direct_tag", 512'(out_tag), 512'(t));
    endtask

    task automatic drain();
        for (int k = 0; k < 100 && q.size() != 0; k++) @(negedge clk);
        check("drain", 512'(q.size()), 512'(0));
        @(posedge clk);
        #1;
    endtask

    task automatic run64(input logic [63:0] a, input logic [63:0] b,
                         input logic [3:0] t, input logic [127:0] e);
        int cnt;
        a64 = a; b64 = b; t64 = t; v64 = 1'b1;
        @(posedge clk);
        #1;
        v64 = 1'b0;
        cnt = 1;
        while (!ov64 && cnt < 20) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        check("latency64", 512'(cnt), 512'(5));
        check("out_p64", 512'(p64), 512'(e));
        check("out_tag64", 512'(ot64), 512'(t));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout, expected test completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [255:0] ones, a, b;
        logic [511:0] e;
        int c0, n0;

        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_tag = '0;
        v64 = 1'b0; a64 = '0; b64 = '0; t64 = '0;
        v8 = 1'b0; a8 = '0; b8 = '0; t8 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 512'(out_valid), 512'(0));
        check("rst_out_p", out_p, 512'(0));
        check("rst_out_tag", 512'(out_tag), 512'(0));
        check("rst_in_ready", 512'(in_ready), 512'(1));
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        ones = '1;
        e = {{255{1'b1}}, 1'b0, {255{1'b0}}, 1'b1};
        timed(ones, ones, 4'd5, e);
        drain();

        // Both halves at 2^127: sa and sb carry into bit 128.
        a = '0; a[255] = 1'b1; a[127] = 1'b1;
        e = '0; e[510] = 1'b1; e[383] = 1'b1; e[254] = 1'b1;
        send(a, a, 4'd1, e);
        a = '0; a[128] = 1'b1; b = a; b[0] = 1'b1;
        e = '0; e[256] = 1'b1; e[128] = 1'b1;
        send(a, b, 4'd2, e);
        send(256'd3, 256'd5, 4'd3, 512'd15);
        send(ones, 256'd0, 4'd4, 512'd0);
        a = '0; a[255] = 1'b1;
        e = '0; e[256] = 1'b1;
        send(a, 256'd2, 4'd6, e);
        drain();

        c0 = cyc; n0 = n_out;
        for (int i = 0; i < 100; i++) begin
            a = rnd256(); b = rnd256();
            send(a, b, 4'(i), 512'(a) * 512'(b));
        end
        check("stream_rate", 512'(cyc - c0), 512'(100));
        drain();
        check("stream_count", 512'(n_out - n0), 512'(100));

        bp_en = 1'b1;
        n0 = n_out;
        for (int i = 0; i < 200; i++) begin
            a = rnd256(); b = rnd256();
            send(a, b, 4'(i), 512'(a) * 512'(b));
        end
        for (int k = 0; k < 2000 && q.size() != 0; k++) @(negedge clk);
        bp_en = 1'b0;
        drain();
        check("bp_count", 512'(n_out - n0), 512'(200));

        for (int i = 0; i < 3; i++) begin
            a = rnd256(); b = rnd256();
            send(a, b, 4'(i + 9), 512'(a) * 512'(b));
        end
        #1;
        rst_n = 1'b0;
        #1;
        check("flush_valid", 512'(out_valid), 512'(0));
        check("flush_p", out_p, 512'(0));
        q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        n0 = n_out;
        repeat (10) @(posedge clk);
        #1;
        check("flush_no_out", 512'(n_out - n0), 512'(0));
        timed(256'h1234_5678, 256'h9abc, 4'd7, 512'h1234_5678 * 512'h9abc);
        drain();

        run64(64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 4'd1, 128'h1_FFFF_FFFF_FFFF_FFFE);
        run64(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 4'd2,
              128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);
        run64(64'h1_0000_0000, 64'h1_0000_0001, 4'd3, 128'h1_0000_0001_0000_0000);

        for (int i = 0; i < 65536; i++) begin
            a8 = i[15:8]; b8 = i[7:0]; t8 = i[3:0]; v8 = 1'b1;
            @(posedge clk);
            #1;
        end
        v8 = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("exh8_count", 512'(n_out8), 512'(65536));
        check("exh8_drain", 512'(q8.size()), 512'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
